// File: rtl/ifu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : ifu_pkg                                                   |
// | Brief   : Shared IFU widths, NOP encoding and instruction buffer    |
// |           entry type.                                               |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package ifu_pkg;
  localparam int INST_DATA_WIDTH = 32;
  localparam int INST_ADDR_WIDTH = 32;
  localparam int CU_BUS_WIDTH    = 4;

  // addi x0, x0, 0
  localparam logic [INST_DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [INST_DATA_WIDTH-1:0] inst;
    logic [INST_ADDR_WIDTH-1:0] addr;
  } ibuf_entry_t;
endpackage
`default_nettype wire

// File: rtl/ifu_inst_buffer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : ifu_inst_buffer_if                                        |
// | Brief   : Fetch-unit to instruction-buffer valid/ready word bus.    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface ifu_inst_buffer_if;
  import ifu_pkg::*;

  logic                       fetch_valid_i;
  logic                       fetch_ready_o;
  logic [INST_DATA_WIDTH-1:0] fetch_inst_i;
  logic [INST_ADDR_WIDTH-1:0] fetch_addr_i;

  modport master (
    output fetch_valid_i,
    output fetch_inst_i,
    output fetch_addr_i,
    input  fetch_ready_o
  );

  modport slave (
    input  fetch_valid_i,
    input  fetch_inst_i,
    input  fetch_addr_i,
    output fetch_ready_o
  );
endinterface
`default_nettype wire

// File: rtl/ifu_ibuf_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : ifu_ibuf_fifo                                             |
// | Brief   : Synchronous FIFO of instruction buffer entries with       |
// |           flush and explicit occupancy count.                       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module ifu_ibuf_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire logic                     flush,
  input  wire ibuf_entry_t              wr_data,
  output ibuf_entry_t                   rd_data,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          empty
);
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  ibuf_entry_t          r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 w_push;
  logic                 w_pop;

  assign full    = (r_count == c_CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;
  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !rst && !flush) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/ifu_inst_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : ifu_inst_buffer                                           |
// | Brief   : Fetch-to-decode instruction buffer with registered IF/ID  |
// |           output, stall hold and redirect flush. Define             |
// |           IBUF_BYPASS_EN for the 1-cycle empty-FIFO bypass.         |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module ifu_inst_buffer
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  ifu_inst_buffer_if.slave                fetch,
  input  wire logic                       flush_i,
  input  wire logic [CU_BUS_WIDTH-1:0]    stall_flag_i,
  output logic [INST_DATA_WIDTH-1:0]      inst_o,
  output logic [INST_ADDR_WIDTH-1:0]      inst_addr_o,
  output logic                            inst_valid_o,
  output logic [$clog2(DEPTH):0]          count_o
);
  logic                       w_hold;
  logic                       w_push_req;
  logic                       w_bypass;
  logic                       w_fifo_push;
  logic                       w_fifo_pop;
  logic                       w_full;
  logic                       w_empty;
  ibuf_entry_t                w_fetch_entry;
  ibuf_entry_t                w_head;
  logic [INST_DATA_WIDTH-1:0] r_inst;
  logic [INST_ADDR_WIDTH-1:0] r_inst_addr;
  logic                       r_inst_valid;

  assign w_hold              = |stall_flag_i;
  assign fetch.fetch_ready_o = !rst && !w_full;
  assign w_push_req          = fetch.fetch_valid_i && fetch.fetch_ready_o && !flush_i;
  assign w_fetch_entry       = '{inst: fetch.fetch_inst_i, addr: fetch.fetch_addr_i};

`ifdef IBUF_BYPASS_EN
  assign w_bypass = w_empty && w_push_req && !w_hold;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word goes straight to the output register and never occupies a slot.
  assign w_fifo_push = w_push_req && !w_bypass;
  assign w_fifo_pop  = !w_hold && !w_empty && !flush_i;

  ifu_ibuf_fifo #(
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_fifo_push),
    .pop     (w_fifo_pop),
    .flush   (flush_i),
    .wr_data (w_fetch_entry),
    .rd_data (w_head),
    .count   (count_o),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Flush outranks hold; a bubble keeps the last PC so decode sees a stable address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst       <= INST_NOP;
      r_inst_addr  <= '0;
      r_inst_valid <= 1'b0;
    end else if (flush_i) begin
      r_inst       <= INST_NOP;
      r_inst_valid <= 1'b0;
    end else if (!w_hold) begin
      if (!w_empty) begin
        r_inst       <= w_head.inst;
        r_inst_addr  <= w_head.addr;
        r_inst_valid <= 1'b1;
      end else if (w_bypass) begin
        r_inst       <= w_fetch_entry.inst;
        r_inst_addr  <= w_fetch_entry.addr;
        r_inst_valid <= 1'b1;
      end else begin
        r_inst       <= INST_NOP;
        r_inst_valid <= 1'b0;
      end
    end
  end

  assign inst_o       = r_inst;
  assign inst_addr_o  = r_inst_addr;
  assign inst_valid_o = r_inst_valid;
endmodule
`default_nettype wire

// File: tb/tb_ifu_inst_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_ifu_inst_buffer                                        |
// | Brief   : Self-checking bench for ifu_inst_buffer (either build of  |
// |           IBUF_BYPASS_EN) against a queue-based reference model.    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_ifu_inst_buffer;
  import ifu_pkg::*;

  localparam int DEPTH = 4;
`ifdef IBUF_BYPASS_EN
  localparam bit c_BYPASS = 1'b1;
`else
  localparam bit c_BYPASS = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       flush = 1'b0;
  logic [CU_BUS_WIDTH-1:0]    stall = '0;
  logic [INST_DATA_WIDTH-1:0] inst_o;
  logic [INST_ADDR_WIDTH-1:0] inst_addr_o;
  logic                       inst_valid_o;
  logic [$clog2(DEPTH):0]     count_o;

  ifu_inst_buffer_if fif ();

  ifu_inst_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch        (fif),
    .flush_i      (flush),
    .stall_flag_i (stall),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: buffered words in a queue plus the decode-side view.
  ibuf_entry_t m_q[$];
  logic [31:0] m_inst  = INST_NOP;
  logic [31:0] m_addr  = '0;
  logic        m_valid = 1'b0;
  logic        accepted;

  typedef struct {
    logic        v;
    logic [31:0] inst;
    logic [31:0] addr;
    logic        stall;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_addr;
    int          e_count;
    logic        e_ready;
  } vec_t;

  vec_t tbl[10];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    ibuf_entry_t w;
    ibuf_entry_t h;
    logic        acc;
    acc = fif.fetch_valid_i && !rst && !flush && (m_q.size() < DEPTH);
    accepted = acc;
    w.inst = fif.fetch_inst_i;
    w.addr = fif.fetch_addr_i;
    if (rst) begin
      m_q.delete();
      m_inst = INST_NOP; m_addr = '0; m_valid = 1'b0;
    end else if (flush) begin
      m_q.delete();
      m_inst = INST_NOP; m_valid = 1'b0;
    end else begin
      if (stall == '0) begin
        if (m_q.size() > 0) begin
          h = m_q.pop_front();
          m_inst = h.inst; m_addr = h.addr; m_valid = 1'b1;
        end else if (c_BYPASS && acc) begin
          m_inst = w.inst; m_addr = w.addr; m_valid = 1'b1;
          acc = 1'b0;
        end else begin
          m_inst = INST_NOP; m_valid = 1'b0;
        end
      end
      if (acc) m_q.push_back(w);
    end
    @(posedge clk);
    #1;
    cmp("model_inst", inst_o, m_inst);
    cmp("model_addr", inst_addr_o, m_addr);
    cmp("model_valid", {31'b0, inst_valid_o}, {31'b0, m_valid});
    cmp("model_count", {29'b0, count_o}, m_q.size());
    cmp("model_ready", {31'b0, fif.fetch_ready_o}, {31'b0, (!rst && m_q.size() < DEPTH)});
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] addr);
    fif.fetch_valid_i = v;
    fif.fetch_inst_i  = inst;
    fif.fetch_addr_i  = addr;
  endtask

  function automatic vec_t mk(input logic v, input logic [31:0] inst, input logic [31:0] addr,
                              input logic st, input logic ev, input logic [31:0] ei,
                              input logic [31:0] ea, input int ec, input logic er);
    vec_t r;
    r.v = v; r.inst = inst; r.addr = addr; r.stall = st;
    r.e_valid = ev; r.e_inst = ei; r.e_addr = ea; r.e_count = ec; r.e_ready = er;
    return r;
  endfunction

  initial begin
    logic [31:0] pc;
    int          k;
    drive(1'b0, '0, '0);

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    cmp("rst_inst", inst_o, 32'h0000_0013);
    cmp("rst_addr", inst_addr_o, 32'h0);
    cmp("rst_valid", {31'b0, inst_valid_o}, 32'h0);
    cmp("rst_count", {29'b0, count_o}, 32'h0);
    cmp("rst_ready", {31'b0, fif.fetch_ready_o}, 32'h0);
    rst = 1'b0;
    #1;
    cmp("ready_after_rst", {31'b0, fif.fetch_ready_o}, 32'h1);

    // Stalled fill to full, 5th word refused, then drain in order
    tbl[0] = mk(1, 32'h0010_0093, 32'h8000_0100, 1, 0, 32'h13, 32'h0, 1, 1);
    tbl[1] = mk(1, 32'h0020_0093, 32'h8000_0104, 1, 0, 32'h13, 32'h0, 2, 1);
    tbl[2] = mk(1, 32'h0030_0093, 32'h8000_0108, 1, 0, 32'h13, 32'h0, 3, 1);
    tbl[3] = mk(1, 32'h0040_0093, 32'h8000_010C, 1, 0, 32'h13, 32'h0, 4, 0);
    tbl[4] = mk(1, 32'h0050_0093, 32'h8000_0110, 1, 0, 32'h13, 32'h0, 4, 0);
    tbl[5] = mk(1, 32'h0050_0093, 32'h8000_0110, 0, 1, 32'h0010_0093, 32'h8000_0100, 3, 1);
    tbl[6] = mk(0, 32'h0, 32'h0, 0, 1, 32'h0020_0093, 32'h8000_0104, 2, 1);
    tbl[7] = mk(0, 32'h0, 32'h0, 0, 1, 32'h0030_0093, 32'h8000_0108, 1, 1);
    tbl[8] = mk(0, 32'h0, 32'h0, 0, 1, 32'h0040_0093, 32'h8000_010C, 0, 1);
    tbl[9] = mk(0, 32'h0, 32'h0, 0, 0, 32'h0000_0013, 32'h8000_010C, 0, 1);
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].inst, tbl[i].addr);
      stall = tbl[i].stall ? 4'b0010 : 4'b0000;
      tick();
      cmp($sformatf("tbl%0d_valid", i), {31'b0, inst_valid_o}, {31'b0, tbl[i].e_valid});
      cmp($sformatf("tbl%0d_inst", i), inst_o, tbl[i].e_inst);
      cmp($sformatf("tbl%0d_addr", i), inst_addr_o, tbl[i].e_addr);
      cmp($sformatf("tbl%0d_count", i), {29'b0, count_o}, tbl[i].e_count);
      cmp($sformatf("tbl%0d_ready", i), {31'b0, fif.fetch_ready_o}, {31'b0, tbl[i].e_ready});
    end
    stall = '0;

    // Fetch-to-decode latency from an empty buffer
    rst = 1'b1; drive(1'b0, '0, '0);
    tick();
    rst = 1'b0;
    drive(1'b1, 32'h0050_0093, 32'h8000_0000);
    tick();
    drive(1'b0, '0, '0);
`ifdef IBUF_BYPASS_EN
    cmp("lat_inst", inst_o, 32'h0050_0093);
    cmp("lat_valid", {31'b0, inst_valid_o}, 32'h1);
`else
    cmp("lat_valid_early", {31'b0, inst_valid_o}, 32'h0);
    tick();
    cmp("lat_inst", inst_o, 32'h0050_0093);
    cmp("lat_valid", {31'b0, inst_valid_o}, 32'h1);
`endif
    tick();

    // Flush with three buffered words and a word offered in the flush cycle
    stall = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0100_0093 + 32'(i), 32'h8000_0200 + 32'(4 * i));
      tick();
    end
    stall = '0; flush = 1'b1;
    drive(1'b1, 32'h0BAD_0093, 32'h8000_0300);
    tick();
    flush = 1'b0;
    cmp("flush_count", {29'b0, count_o}, 32'h0);
    cmp("flush_inst", inst_o, 32'h0000_0013);
    cmp("flush_valid", {31'b0, inst_valid_o}, 32'h0);
    drive(1'b1, 32'h0077_0093, 32'h8000_0400);
    tick();
    drive(1'b0, '0, '0);
    k = 0;
    while (!inst_valid_o && k < 4) begin
      tick();
      k++;
    end
    cmp("post_flush_first", inst_o, 32'h0077_0093);

    // Stall and flush together: flush wins
    stall = 4'b1000; flush = 1'b1;
    tick();
    stall = '0; flush = 1'b0;
    cmp("stallflush_inst", inst_o, 32'h0000_0013);
    cmp("stallflush_valid", {31'b0, inst_valid_o}, 32'h0);

    // Reset while words are buffered
    stall = 4'b0001;
    drive(1'b1, 32'h0123_0093, 32'h8000_0500);
    tick();
    drive(1'b1, 32'h0124_0093, 32'h8000_0504);
    tick();
    rst = 1'b1;
    tick();
    cmp("midrst_count", {29'b0, count_o}, 32'h0);
    cmp("midrst_addr", inst_addr_o, 32'h0);
    cmp("midrst_ready", {31'b0, fif.fetch_ready_o}, 32'h0);
    rst = 1'b0; stall = '0; drive(1'b0, '0, '0);

    // Randomized traffic against the model
    pc = 32'h8000_1000;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom, pc);
      stall = '0;
      if ($urandom_range(0, 2) == 0) stall[$urandom_range(0, CU_BUS_WIDTH - 1)] = 1'b1;
      flush = ($urandom_range(0, 39) == 0);
      tick();
      if (accepted) pc = pc + 32'd4;
    end
    flush = 1'b0; stall = '0; drive(1'b0, '0, '0);
    for (int c = 0; c < 6; c++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
